ysyx_22040759_hazard_ctrl: RTL and testbench
============================================

Name: ysyx_22040759_hazard_ctrl

Overview:
Pipeline hazard scheduler for the 5-stage AXI RV64 core. It drives the ID-stage control inputs: en_control (bubble into EX), IF_ID_write (freeze IF/ID) and jump_r (squash the ID instruction to NOP). It sequences three hazard classes: load-use stalls, multi-cycle mul/div occupancy of EX, and multi-cycle wrong-path flush after a taken branch or jump. It also keeps a stall performance counter and a mul/div watchdog flag.

Parameters:
FLUSH_CYCLES, 2, number of consecutive cycles jump_r is asserted after br_taken (range 1..15).
MD_TIMEOUT, 64, maximum cycles in MD_BUSY before the watchdog trips (range 2..255).
STALL_CNT_W, 32, width of the stall performance counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ds_valid  in  1  ID stage holds a valid instruction
ds_rs1  in  5  ID source register 1 address
ds_rs2  in  5  ID source register 2 address
es_valid  in  1  EX stage holds a valid instruction
es_mem_ren  in  1  EX instruction is a load
es_reg_wen  in  1  EX instruction writes rd
es_rd  in  5  EX destination register
es_is_muldiv  in  1  EX instruction is mul/div/rem (any width)
muldiv_done  in  1  mul/div unit result valid this cycle
br_taken  in  1  branch/jump redirect resolved this cycle
en_control  out  1  force ID control bundle to zero (bubble)
IF_ID_write  out  1  hold IF/ID register (1 = freeze)
jump_r  out  1  replace ID instruction with NOP (0x13) and zero ID PC
md_timeout  out  1  sticky: mul/div exceeded MD_TIMEOUT
stall_cnt  out  STALL_CNT_W  saturating count of cycles with IF_ID_write=1
state_o  out  2  current FSM state (debug)

Behaviour:
- Interface: one clock clk; rst is synchronous, active-high.
- Reset: state=RUN; flush and mul/div counters=0; md_timeout=0; stall_cnt=0. Outputs en_control, IF_ID_write and jump_r read 0 in the cycle after rst is sampled.
- States (2-bit encoding): RUN=0, MD_BUSY=1, FLUSH=2; 3 is unused and returns to RUN.
- Outputs are combinational from state and current inputs. State, counters and flags are registered.
- load_use = ds_valid & es_valid & es_mem_ren & es_reg_wen & (es_rd!=0) & (es_rd==ds_rs1 | es_rd==ds_rs2).
- Priority every cycle: br_taken > MD_BUSY hold > load_use.
- br_taken in any state: jump_r=1 this cycle; next state FLUSH; flush_cnt<=FLUSH_CYCLES-1; mul/div counter cleared.
- FLUSH: jump_r=1, en_control=0, IF_ID_write=0. flush_cnt decrements each cycle; on 0 the next state is RUN. If FLUSH_CYCLES=1, br_taken leads to RUN directly. load_use is ignored in FLUSH. A new br_taken reloads the count.
- RUN, load_use=1: en_control=1 and IF_ID_write=1 for that cycle only; state stays RUN. The load advances to MEM, so load_use clears the next cycle.
- RUN, es_valid & es_is_muldiv & !muldiv_done: IF_ID_write=1 this cycle; next state MD_BUSY; md_cnt<=1. If muldiv_done is 1 in the same cycle, no stall and state stays RUN.
- MD_BUSY: IF_ID_write=1, en_control=0. md_cnt increments each cycle.
  - muldiv_done=1: IF_ID_write=0 that cycle; next state RUN.
  - md_cnt==MD_TIMEOUT-1 without done: md_timeout<=1 (sticky until rst); next state RUN.
- stall_cnt increments on each cycle with IF_ID_write=1 and saturates at all-ones.
- Reset mid-operation: returns to RUN immediately and drops every output, with no residual flush.

Decomposition:
- Shared package/define file: state encodings HZ_RUN/HZ_MD_BUSY/HZ_FLUSH and the NOP constant 32'h13.
- Optional sub-module ysyx_22040759_hazard_detect: pure combinational load_use compare, reusable for forwarding checks.

Test Plan:
- Reset: hold rst for 3 cycles with br_taken=1 -> all outputs 0, state_o=0, stall_cnt=0.
- Load-use: es lw x5 (es_rd=5, es_mem_ren=1), ds_rs2=5 -> en_control=1, IF_ID_write=1 for exactly 1 cycle, stall_cnt=1. Repeat with es_rd=0 -> no stall.
- Mul/div: es_is_muldiv=1, muldiv_done at cycle 10 -> IF_ID_write=1 for cycles 0..9, 0 at cycle 10, state_o=0 at cycle 11, stall_cnt=10.
- Watchdog: MD_TIMEOUT=64, muldiv_done never asserted -> md_timeout=1 after 64 cycles, state RUN; flag stays 1 until rst.
- Flush: br_taken pulse with FLUSH_CYCLES=2 and load_use held high -> jump_r=1 for 2 cycles, en_control=0 throughout. A second br_taken in flush cycle 2 extends jump_r to 3 cycles total.
- Collision: br_taken while in MD_BUSY -> jump_r=1 and IF_ID_write=0 that cycle, state FLUSH, md_timeout stays 0.

Source files
------------

// File: rtl/ysyx_22040759_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040759_hazard_pkg
// Description : Shared state encodings and constants for the hazard scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040759_hazard_pkg;

  // Scheduler state encoding; value 3 is unused and recovers to RUN.
  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_MD_BUSY = 2'd1,
    HZ_FLUSH   = 2'd2,
    HZ_RSVD    = 2'd3
  } hz_state_e;

  // Instruction the ID stage substitutes when jump_r squashes it (addi x0,x0,0).
  localparam logic [31:0] HZ_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040759_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040759_hazard_detect
// Description : Combinational load-use compare between the ID and EX stages.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040759_hazard_detect (
  input  logic       ds_valid,
  input  logic [4:0] ds_rs1,
  input  logic [4:0] ds_rs2,
  input  logic       es_valid,
  input  logic       es_mem_ren,
  input  logic       es_reg_wen,
  input  logic [4:0] es_rd,
  output logic       load_use
);

  logic rd_match;

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  always_comb begin
    rd_match = (es_rd == ds_rs1) | (es_rd == ds_rs2);
    load_use = ds_valid & es_valid & es_mem_ren & es_reg_wen &
               (es_rd != 5'd0) & rd_match;
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040759_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040759_hazard_ctrl
// Description : Pipeline hazard scheduler: load-use stall, mul/div occupancy
//               of EX with watchdog, multi-cycle wrong-path flush, and a
//               saturating stall performance counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040759_hazard_ctrl
  import ysyx_22040759_hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MD_TIMEOUT   = 64,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ds_valid,
  input  logic [4:0]             ds_rs1,
  input  logic [4:0]             ds_rs2,
  input  logic                   es_valid,
  input  logic                   es_mem_ren,
  input  logic                   es_reg_wen,
  input  logic [4:0]             es_rd,
  input  logic                   es_is_muldiv,
  input  logic                   muldiv_done,
  input  logic                   br_taken,
  output logic                   en_control,
  output logic                   IF_ID_write,
  output logic                   jump_r,
  output logic                   md_timeout,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             state_o
);

  // Flush counter holds the number of FLUSH cycles still to come, including
  // the current one; the branch cycle itself is the first jump_r cycle.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] MD_LIMIT   = 8'(MD_TIMEOUT - 1);

  hz_state_e              state_q, state_d;
  logic [3:0]             flush_cnt_q, flush_cnt_d;
  logic [7:0]             md_cnt_q, md_cnt_d;
  logic                   md_timeout_q, md_timeout_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic md_start;
  logic en_raw, ifid_raw, jump_raw;

  ysyx_22040759_hazard_detect u_detect (
    .ds_valid   (ds_valid),
    .ds_rs1     (ds_rs1),
    .ds_rs2     (ds_rs2),
    .es_valid   (es_valid),
    .es_mem_ren (es_mem_ren),
    .es_reg_wen (es_reg_wen),
    .es_rd      (es_rd),
    .load_use   (load_use)
  );

  // Next-state and raw outputs; a redirect overrides every other hazard.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    md_cnt_d     = md_cnt_q;
    md_timeout_d = md_timeout_q;
    en_raw       = 1'b0;
    ifid_raw     = 1'b0;
    jump_raw     = 1'b0;
    md_start     = es_valid & es_is_muldiv & ~muldiv_done;

    if (br_taken) begin
      jump_raw    = 1'b1;
      md_cnt_d    = 8'd0;
      flush_cnt_d = FLUSH_LOAD;
      state_d     = (FLUSH_CYCLES == 1) ? HZ_RUN : HZ_FLUSH;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (md_start) begin
            ifid_raw = 1'b1;
            md_cnt_d = 8'd1;
            state_d  = HZ_MD_BUSY;
          end else if (load_use) begin
            en_raw   = 1'b1;
            ifid_raw = 1'b1;
          end
        end
        HZ_MD_BUSY: begin
          md_cnt_d = md_cnt_q + 8'd1;
          if (muldiv_done) begin
            md_cnt_d = 8'd0;
            state_d  = HZ_RUN;
          end else begin
            ifid_raw = 1'b1;
            if (md_cnt_q == MD_LIMIT) begin
              md_timeout_d = 1'b1;
              md_cnt_d     = 8'd0;
              state_d      = HZ_RUN;
            end
          end
        end
        HZ_FLUSH: begin
          jump_raw = 1'b1;
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_d = 4'd0;
            state_d     = HZ_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = HZ_RUN;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is asserted so no stale action leaks.
  always_comb begin
    en_control  = en_raw & ~rst;
    IF_ID_write = ifid_raw & ~rst;
    jump_r      = jump_raw & ~rst;
    stall_cnt_d = stall_cnt_q;
    if (IF_ID_write && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, counters and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HZ_RUN;
      flush_cnt_q  <= 4'd0;
      md_cnt_q     <= 8'd0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      md_cnt_q     <= md_cnt_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign md_timeout = md_timeout_q;
  assign stall_cnt  = stall_cnt_q;
  assign state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040759_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040759_hazard_ctrl
// Description : Directed self-checking bench for the hazard scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040759_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ds_valid;
  logic [4:0]  ds_rs1, ds_rs2;
  logic        es_valid, es_mem_ren, es_reg_wen;
  logic [4:0]  es_rd;
  logic        es_is_muldiv, muldiv_done, br_taken;
  logic        en_control, IF_ID_write, jump_r, md_timeout;
  logic [31:0] stall_cnt;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22040759_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MD_TIMEOUT   (64),
    .STALL_CNT_W  (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ds_valid     (ds_valid),
    .ds_rs1       (ds_rs1),
    .ds_rs2       (ds_rs2),
    .es_valid     (es_valid),
    .es_mem_ren   (es_mem_ren),
    .es_reg_wen   (es_reg_wen),
    .es_rd        (es_rd),
    .es_is_muldiv (es_is_muldiv),
    .muldiv_done  (muldiv_done),
    .br_taken     (br_taken),
    .en_control   (en_control),
    .IF_ID_write  (IF_ID_write),
    .jump_r       (jump_r),
    .md_timeout   (md_timeout),
    .stall_cnt    (stall_cnt),
    .state_o      (state_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge, where inputs are driven.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge, where outputs are sampled.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ds_valid = 0; ds_rs1 = 0; ds_rs2 = 0;
    es_valid = 0; es_mem_ren = 0; es_reg_wen = 0; es_rd = 0;
    es_is_muldiv = 0; muldiv_done = 0; br_taken = 0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ds_valid = 1; ds_rs1 = rs1; ds_rs2 = rs2;
    es_valid = 1; es_mem_ren = 1; es_reg_wen = 1; es_rd = rd;
  endtask

  initial begin
    idle_inputs();
    rst = 1; br_taken = 1;

    // ---------------- reset with br_taken held ----------------
    @(posedge clk); @(posedge clk);
    smp();
    chk("rst_jump", jump_r, 0);
    chk("rst_en", en_control, 0);
    chk("rst_ifid", IF_ID_write, 0);
    nxt();
    rst = 0; br_taken = 0;
    smp();
    chk("rst_state", state_o, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_mdto", md_timeout, 0);
    chk("rst_jump2", jump_r, 0);
    chk("rst_ifid2", IF_ID_write, 0);

    // ---------------- load-use ----------------
    nxt(); set_load(5'd5, 5'd1, 5'd5);
    smp();
    chk("lu_en", en_control, 1);
    chk("lu_ifid", IF_ID_write, 1);
    chk("lu_jump", jump_r, 0);
    nxt(); idle_inputs();
    smp();
    chk("lu_en_clr", en_control, 0);
    chk("lu_ifid_clr", IF_ID_write, 0);
    chk("lu_stall1", stall_cnt, 1);
    nxt(); set_load(5'd0, 5'd0, 5'd0);
    smp();
    chk("lu_x0_en", en_control, 0);
    chk("lu_x0_ifid", IF_ID_write, 0);
    nxt(); set_load(5'd7, 5'd7, 5'd3);
    smp();
    chk("lu_rs1_en", en_control, 1);
    nxt(); set_load(5'd7, 5'd7, 5'd3); es_mem_ren = 0;
    smp();
    chk("lu_noload_en", en_control, 0);
    chk("lu_stall2", stall_cnt, 2);

    // ---------------- mul/div, done at cycle 10 ----------------
    nxt(); idle_inputs(); es_valid = 1; es_is_muldiv = 1;
    for (int i = 0; i <= 10; i++) begin
      muldiv_done = (i == 10);
      smp();
      chk($sformatf("md_ifid_c%0d", i), IF_ID_write, (i < 10) ? 1 : 0);
      chk($sformatf("md_en_c%0d", i), en_control, 0);
      chk($sformatf("md_state_c%0d", i), state_o, (i == 0) ? 0 : 1);
      nxt();
    end
    idle_inputs();
    smp();
    chk("md_state_after", state_o, 0);
    chk("md_stall", stall_cnt, 12);

    // ---------------- mul/div completes in its first cycle ----------------
    nxt(); es_valid = 1; es_is_muldiv = 1; muldiv_done = 1;
    smp();
    chk("md0_ifid", IF_ID_write, 0);
    nxt(); idle_inputs();
    smp();
    chk("md0_state", state_o, 0);
    chk("md0_stall", stall_cnt, 12);

    // ---------------- watchdog ----------------
    nxt(); es_valid = 1; es_is_muldiv = 1;
    for (int i = 0; i < 64; i++) begin
      smp();
      if (i == 0 || i == 62 || i == 63) begin
        chk($sformatf("wd_ifid_c%0d", i), IF_ID_write, 1);
        chk($sformatf("wd_mdto_c%0d", i), md_timeout, 0);
      end
      nxt();
    end
    idle_inputs();
    smp();
    chk("wd_mdto", md_timeout, 1);
    chk("wd_state", state_o, 0);
    chk("wd_ifid_off", IF_ID_write, 0);
    chk("wd_stall", stall_cnt, 76);
    nxt(); nxt(); nxt();
    smp();
    chk("wd_sticky", md_timeout, 1);

    // ---------------- flush with load-use held ----------------
    nxt(); set_load(5'd5, 5'd5, 5'd2); br_taken = 1;
    smp();
    chk("fl_jump_c0", jump_r, 1);
    chk("fl_en_c0", en_control, 0);
    chk("fl_ifid_c0", IF_ID_write, 0);
    nxt(); br_taken = 0;
    smp();
    chk("fl_state_c1", state_o, 2);
    chk("fl_jump_c1", jump_r, 1);
    chk("fl_en_c1", en_control, 0);
    chk("fl_ifid_c1", IF_ID_write, 0);
    nxt();
    smp();
    chk("fl_state_c2", state_o, 0);
    chk("fl_jump_c2", jump_r, 0);
    chk("fl_en_c2", en_control, 1);
    nxt(); idle_inputs();
    smp();
    chk("fl_stall", stall_cnt, 77);

    // ---------------- re-branch inside flush ----------------
    nxt(); br_taken = 1;
    smp();
    chk("rb_jump_c0", jump_r, 1);
    nxt(); br_taken = 1;
    smp();
    chk("rb_jump_c1", jump_r, 1);
    chk("rb_state_c1", state_o, 2);
    nxt(); br_taken = 0;
    smp();
    chk("rb_jump_c2", jump_r, 1);
    chk("rb_state_c2", state_o, 2);
    nxt();
    smp();
    chk("rb_jump_c3", jump_r, 0);
    chk("rb_state_c3", state_o, 0);

    // ---------------- reset clears sticky flag and counter ----------------
    nxt(); rst = 1;
    nxt(); rst = 0;
    smp();
    chk("rst2_mdto", md_timeout, 0);
    chk("rst2_stall", stall_cnt, 0);

    // ---------------- branch collides with mul/div busy ----------------
    nxt(); es_valid = 1; es_is_muldiv = 1;
    smp();
    chk("co_ifid_c0", IF_ID_write, 1);
    nxt();
    smp();
    chk("co_state_c1", state_o, 1);
    nxt(); br_taken = 1;
    smp();
    chk("co_jump_c2", jump_r, 1);
    chk("co_ifid_c2", IF_ID_write, 0);
    chk("co_en_c2", en_control, 0);
    nxt(); idle_inputs();
    smp();
    chk("co_state_c3", state_o, 2);
    chk("co_mdto_c3", md_timeout, 0);
    chk("co_jump_c3", jump_r, 1);
    nxt();
    smp();
    chk("co_state_c4", state_o, 0);

    // ---------------- reset in the middle of a flush ----------------
    nxt(); br_taken = 1;
    nxt(); br_taken = 0; rst = 1;
    smp();
    chk("mr_jump_rst", jump_r, 0);
    nxt(); rst = 0;
    smp();
    chk("mr_state", state_o, 0);
    chk("mr_jump", jump_r, 0);
    chk("mr_stall", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
